// File: rtl/line_write_buffer.sv
// Line-granular write buffer between the L1 pmem port and physical memory.
// Absorbs write-backs in a circular FIFO, drains in the background, forwards hits to reads.
//
// state | meaning
// IDLE  | arbitrate cache read > cache write > background drain
// RESP  | one-cycle mem_resp pulse, cache requests ignored
// DRAIN | head line on pmem write port, waiting for pmem_resp
// FETCH | missed line on pmem read port, waiting for pmem_resp
module line_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    output logic         mem_resp,
    output logic [255:0] mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESP  = 2'd1,
        S_DRAIN = 2'd2,
        S_FETCH = 2'd3
    } state_t;

    state_t        state_q, state_d;

    logic [DEPTH-1:0] valid_q;
    logic [26:0]      tag_q  [DEPTH];
    logic [255:0]     data_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;

    logic [255:0]     mem_rdata_q;
    logic [31:0]      pmem_address_q;
    logic [255:0]     pmem_wdata_q;

    logic [26:0]      req_tag;
    logic             addr_offset_unused;
    logic             full, empty;
    logic             hit;
    logic [PW-1:0]    hit_idx, scan_idx;

    logic             in_idle;
    logic             rd_hit, rd_miss, wr_merge, wr_push, drain_go, pop, fetch_done;

    assign req_tag            = mem_address[31:5];
    assign addr_offset_unused = ^mem_address[4:0];
    assign full               = (count_q == FULL_CNT);
    assign empty              = (count_q == '0);

    // Scan oldest to newest so the newest matching entry wins. Lookup only
    // matters in IDLE, where no drain is in flight, so the head is never
    // locked at lookup time and coalescing keeps tags unique.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = head_q;
        scan_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (valid_q[scan_idx] && (tag_q[scan_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem_read) begin
                    state_d = hit ? S_RESP : S_FETCH;
                end else if (mem_write) begin
                    state_d = (hit || !full) ? S_RESP : S_DRAIN;
                end else if (!empty) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_DRAIN: if (pmem_resp) state_d = S_IDLE;
            S_FETCH: if (pmem_resp) state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_idle    = (state_q == S_IDLE);
        mem_resp   = (state_q == S_RESP);
        pmem_read  = (state_q == S_FETCH);
        pmem_write = (state_q == S_DRAIN);

        rd_hit     = in_idle && mem_read && hit;
        rd_miss    = in_idle && mem_read && !hit;
        wr_merge   = in_idle && !mem_read && mem_write && hit;
        wr_push    = in_idle && !mem_read && mem_write && !hit && !full;
        // A write blocked by a full buffer forces the head out; it is retried from IDLE.
        drain_go   = in_idle && !mem_read &&
                     ((mem_write && !hit && full) || (!mem_write && !empty));
        pop        = (state_q == S_DRAIN) && pmem_resp;
        fetch_done = (state_q == S_FETCH) && pmem_resp;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_merge) begin
                data_q[hit_idx] <= mem_wdata;
            end
            if (wr_push) begin
                tag_q[tail_q]  <= req_tag;
                data_q[tail_q] <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            mem_rdata_q    <= '0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            if (wr_push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
                count_q         <= count_q + 1'b1;
            end else if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
                count_q         <= count_q - 1'b1;
            end

            if (rd_hit) begin
                mem_rdata_q <= data_q[hit_idx];
            end else if (fetch_done) begin
                mem_rdata_q <= pmem_rdata;
            end

            if (drain_go) begin
                pmem_address_q <= {tag_q[head_q], 5'b0};
                pmem_wdata_q   <= data_q[head_q];
            end else if (rd_miss) begin
                pmem_address_q <= {req_tag, 5'b0};
            end
        end
    end

    assign mem_rdata    = mem_rdata_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_line_write_buffer.sv
// Bench for line_write_buffer: vector table, directed corner sequences and
// random traffic against a flat coherent-memory view of the cache's world.
module tb_line_write_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [255:0] mem_wdata = '0;
    logic         mem_resp;
    logic [255:0] mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp = 1'b0;
    logic [255:0] pmem_rdata = '0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0]  a;
        logic [255:0] d;
    } wr_t;

    typedef struct {
        bit           wr;
        logic [31:0]  a;
        logic [255:0] wd;
        int           exp_lat;
        logic [255:0] exp_rd;
    } vec_t;

    bit           mem_auto = 1'b0;
    int           mem_lat = 0;
    int           lat_cnt = 0;
    logic [255:0] pmem [logic [31:0]];
    wr_t          wr_log [$];
    int           rd_cycles = 0;
    int           viol = 0;
    logic         prev_resp = 1'b0;

    always #5 clk = ~clk;

    line_write_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    function automatic logic [255:0] def_line(input logic [31:0] a);
        logic [31:0] w;
        w = a ^ 32'h5A5A_0000;
        return {8{w}};
    endfunction

    function automatic logic [255:0] pat(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(k);
        return {8{w}};
    endfunction

    function automatic logic [255:0] mem_val(input logic [31:0] a);
        return pmem.exists(a) ? pmem[a] : def_line(a);
    endfunction

    // Physical memory: answers a held request after mem_lat extra cycles with a one-cycle pulse.
    always @(negedge clk) begin
        if (!rst_n || !mem_auto) begin
            pmem_resp = 1'b0;
            lat_cnt   = 0;
        end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            lat_cnt   = 0;
        end else if (pmem_read || pmem_write) begin
            if (lat_cnt >= mem_lat) begin
                pmem_resp = 1'b1;
                if (pmem_write) begin
                    pmem[pmem_address] = pmem_wdata;
                    wr_log.push_back('{pmem_address, pmem_wdata});
                end else begin
                    pmem_rdata = mem_val(pmem_address);
                end
            end else begin
                lat_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (pmem_read === 1'b1) rd_cycles++;
        if (pmem_read === 1'b1 && pmem_write === 1'b1) viol++;
        if (mem_resp === 1'b1 && prev_resp === 1'b1) viol++;
        if (pmem_address[4:0] !== 5'b0) viol++;
        prev_resp = mem_resp;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) to_edge();
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after mem_resp so
    // a following call presents its request back to back.
    task automatic cache_op(input bit wr, input logic [31:0] a, input logic [255:0] wd,
                            output logic [255:0] rd, output int lat);
        int n;
        bit got;
        mem_read    = !wr;
        mem_write   = wr;
        mem_address = a;
        mem_wdata   = wr ? wd : '0;
        n   = 0;
        got = 1'b0;
        rd  = '0;
        lat = -1;
        while (!got && n < 400) begin
            @(negedge clk);
            if (mem_resp === 1'b1) begin
                got = 1'b1;
                rd  = mem_rdata;
                lat = n;
            end
            n++;
        end
        to_edge();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL op_timeout: addr %h got no mem_resp, want one within 400 cycles", a);
        end
    endtask

    task automatic wait_log(input int n);
        int k;
        k = 0;
        while (wr_log.size() < n && k < 600) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (wr_log.size() < n) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d memory writes, want %0d", wr_log.size(), n);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] a, input logic [255:0] d);
        if (idx < wr_log.size()) begin
            chk({name, "_addr"}, 256'(wr_log[idx].a), 256'(a));
            chk({name, "_data"}, wr_log[idx].d, d);
        end else begin
            total++;
            bad++;
            $display("FAIL %s: got no memory write #%0d, want addr %h", name, idx, a);
        end
    endtask

    initial begin
        vec_t         vecs [11];
        logic [255:0] rd;
        int           lat;
        int           base;
        int           rc0;
        int           lats [5];
        int           logsz;
        bit           stable;
        logic [255:0] cache_view [logic [31:0]];
        logic [31:0]  line;
        logic [255:0] wd;
        bit           wr;

        vecs[0]  = '{1'b1, 32'h0000_0100, pat(0), 1, '0};
        vecs[1]  = '{1'b0, 32'h0000_0104, '0,     1, pat(0)};
        vecs[2]  = '{1'b1, 32'h0000_0120, pat(1), 1, '0};
        vecs[3]  = '{1'b1, 32'h0000_0100, pat(2), 1, '0};
        vecs[4]  = '{1'b0, 32'h0000_011F, '0,     1, pat(2)};
        vecs[5]  = '{1'b0, 32'h0000_0200, '0,     4, def_line(32'h200)};
        vecs[6]  = '{1'b1, 32'h0000_0140, pat(3), 1, '0};
        vecs[7]  = '{1'b1, 32'h0000_0160, pat(4), 1, '0};
        vecs[8]  = '{1'b0, 32'h0000_0160, '0,     1, pat(4)};
        vecs[9]  = '{1'b1, 32'h0000_0120, pat(5), 1, '0};
        vecs[10] = '{1'b0, 32'h0000_0120, '0,     1, pat(5)};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem_resp",   256'(mem_resp), 256'(0));
        chk("rst_mem_rdata",  mem_rdata, '0);
        chk("rst_pmem_rw",    256'({pmem_read, pmem_write}), 256'(0));
        chk("rst_pmem_addr",  256'(pmem_address), 256'(0));
        chk("rst_pmem_wdata", pmem_wdata, '0);
        to_edge();

        // Vector table: back-to-back ops, memory latency 2.
        mem_auto = 1'b1;
        mem_lat  = 2;
        base     = wr_log.size();
        for (int i = 0; i < 11; i++) begin
            cache_op(vecs[i].wr, vecs[i].a, vecs[i].wd, rd, lat);
            chk($sformatf("vec%0d_lat", i), 256'(lat), 256'(vecs[i].exp_lat));
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end
        chk("vec_no_early_drain", 256'(wr_log.size()), 256'(base));
        wait_log(base + 4);
        chk_log("vec_drain0", base + 0, 32'h100, pat(2));
        chk_log("vec_drain1", base + 1, 32'h120, pat(5));
        chk_log("vec_drain2", base + 2, 32'h140, pat(3));
        chk_log("vec_drain3", base + 3, 32'h160, pat(4));

        // Single write, memory stalled: drain request held stable.
        mem_auto = 1'b0;
        base     = wr_log.size();
        cache_op(1'b1, 32'h40, pat(10), rd, lat);
        chk("w1_lat", 256'(lat), 256'(1));
        @(negedge clk);
        @(negedge clk);
        chk("w1_pmem_write", 256'(pmem_write), 256'(1));
        chk("w1_pmem_addr",  256'(pmem_address), 256'(32'h40));
        chk("w1_pmem_wdata", pmem_wdata, pat(10));
        stable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (!(pmem_write === 1'b1 && pmem_address === 32'h40 && pmem_wdata === pat(10)))
                stable = 1'b0;
        end
        chk("w1_drain_hold", 256'(stable), 256'(1));
        #1;
        mem_lat  = 0;
        mem_auto = 1'b1;
        wait_log(base + 1);
        chk_log("w1_drain", base, 32'h40, pat(10));

        // Read hit on a buffered line before its drain.
        mem_auto = 1'b0;
        base     = wr_log.size();
        rc0      = rd_cycles;
        cache_op(1'b1, 32'h60, pat(11), rd, lat);
        cache_op(1'b0, 32'h65, '0, rd, lat);
        chk("fwd_lat",   256'(lat), 256'(1));
        chk("fwd_rdata", rd, pat(11));
        chk("fwd_no_pmem_read", 256'(rd_cycles), 256'(rc0));
        mem_auto = 1'b1;
        wait_log(base + 1);

        // Write to the line whose drain is in flight enqueues a second copy.
        mem_lat = 8;
        base    = wr_log.size();
        cache_op(1'b1, 32'h40, pat(20), rd, lat);
        idle_cycles(2);
        cache_op(1'b1, 32'h40, pat(21), rd, lat);
        chk("lock_waited", 256'(lat > 1), 256'(1));
        wait_log(base + 2);
        chk_log("lock_first",  base + 0, 32'h40, pat(20));
        chk_log("lock_second", base + 1, 32'h40, pat(21));
        chk("lock_final_mem", mem_val(32'h40), pat(21));

        // Fill to DEPTH with slow memory; fifth write waits for a slot.
        mem_lat = 10;
        base    = wr_log.size();
        for (int k = 0; k < 5; k++) begin
            cache_op(1'b1, 32'h800 + 32'(k * 32), pat(30 + k), rd, lat);
            lats[k] = lat;
        end
        logsz = wr_log.size();
        for (int k = 0; k < 4; k++) chk($sformatf("full_lat%0d", k), 256'(lats[k]), 256'(1));
        chk("full_fifth_waits", 256'(lats[4] > 10), 256'(1));
        chk("full_one_drain_before_fifth", 256'(logsz), 256'(base + 1));
        wait_log(base + 5);
        for (int k = 0; k < 5; k++)
            chk_log($sformatf("full_drain%0d", k), base + k, 32'h800 + 32'(k * 32), pat(30 + k));

        // Read miss takes priority over pending drains.
        mem_lat = 3;
        base    = wr_log.size();
        rc0     = rd_cycles;
        for (int k = 0; k < 3; k++) cache_op(1'b1, 32'h900 + 32'(k * 32), pat(40 + k), rd, lat);
        cache_op(1'b0, 32'h1000, '0, rd, lat);
        chk("miss_rdata", rd, def_line(32'h1000));
        chk("miss_no_drain_first", 256'(wr_log.size()), 256'(base));
        chk("miss_issued_read", 256'(rd_cycles > rc0), 256'(1));
        wait_log(base + 3);
        for (int k = 0; k < 3; k++)
            chk_log($sformatf("miss_drain%0d", k), base + k, 32'h900 + 32'(k * 32), pat(40 + k));

        // Reset in the middle of a drain loses the line.
        mem_auto = 1'b0;
        base     = wr_log.size();
        cache_op(1'b1, 32'hA0, pat(50), rd, lat);
        idle_cycles(3);
        rst_n = 1'b0;
        to_edge();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_pmem_write", 256'(pmem_write), 256'(0));
        chk("rst_mid_mem_resp",   256'(mem_resp), 256'(0));
        to_edge();
        rc0      = rd_cycles;
        mem_lat  = 1;
        mem_auto = 1'b1;
        cache_op(1'b0, 32'hA0, '0, rd, lat);
        chk("rst_mid_read_issued", 256'(rd_cycles > rc0), 256'(1));
        chk("rst_mid_read_data",   rd, def_line(32'hA0));
        idle_cycles(5);
        chk("rst_mid_line_lost", 256'(wr_log.size()), 256'(base));

        // Random traffic over six lines against a coherent-memory view.
        for (int n = 0; n < 250; n++) begin
            idle_cycles($urandom_range(0, 2));
            mem_lat = $urandom_range(0, 4);
            line    = 32'h4000 + 32'($urandom_range(0, 5) * 32);
            wr      = 1'($urandom_range(0, 1));
            for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom;
            cache_op(wr, line + 32'($urandom_range(0, 31)), wd, rd, lat);
            if (wr) begin
                cache_view[line] = wd;
            end else begin
                chk($sformatf("rand%0d_read_%h", n, line), rd,
                    cache_view.exists(line) ? cache_view[line] : def_line(line));
            end
        end
        idle_cycles(150);
        foreach (cache_view[a]) chk($sformatf("rand_final_%h", a), mem_val(a), cache_view[a]);

        chk("protocol_violations", 256'(viol), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
